div_exec_unit: RTL and testbench

Iterative 32-bit integer divide/remainder execution unit. It sits between the divide issue queue and the CDB issue unit.
- Takes one ready DIV/DIVU/REM/REMU op when the issue unit grants it.
- Holds busy while the op is computing.
- Presents result and tag on div_result/div_tag exactly LATENCY cycles after the grant, which is the cycle the issue unit's 6-deep divide select pipe routes it onto the CDB.

---
 rtl/div_pkg.sv | 26 ++
 rtl/div_step.sv | 36 +++
 rtl/div_exec_unit.sv | 168 ++++++++++++++++
 tb/tb_div_exec_unit.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative integer divide execution unit.
package div_pkg;

  localparam int unsigned DIV_LATENCY = 6;
  localparam int unsigned TAG_W       = 6;
  localparam int unsigned XLEN        = 32;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_func_e;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIXUP,
    DONE
  } div_state_e;

  function automatic logic func_is_signed(input div_func_e f);
    return (f == DIV) || (f == REM);
  endfunction

endpackage

// File: rtl/div_step.sv
// Combinational unrolled restoring-divide step: resolves BITS quotient bits, MSB first.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned BITS = 8
) (
  input  logic [XLEN:0]   rem_i,
  input  logic [BITS-1:0] bits_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN:0]   rem_o,
  output logic [BITS-1:0] q_o
);

  logic [XLEN:0]   r;
  logic [BITS-1:0] b;
  logic [BITS-1:0] q;

  always_comb begin
    r = rem_i;
    b = bits_i;
    q = '0;
    for (int unsigned i = 0; i < BITS; i++) begin
      r = {r[XLEN-1:0], b[BITS-1]};
      b = b << 1;
      if (r >= {1'b0, divisor_i}) begin
        r = r - {1'b0, divisor_i};
        q = {q[BITS-2:0], 1'b1};
      end else begin
        q = {q[BITS-2:0], 1'b0};
      end
    end
    rem_o = r;
    q_o   = q;
  end

endmodule

// File: rtl/div_exec_unit.sv
// Iterative 32-bit DIV/DIVU/REM/REMU unit; result and tag appear LATENCY cycles after grant.
module div_exec_unit
  import div_pkg::*;
#(
  parameter int unsigned LATENCY       = 6,
  parameter int unsigned BITS_PER_STEP = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [1:0]       op_func,
  input  logic [31:0]      op_a,
  input  logic [31:0]      op_b,
  input  logic [TAG_W-1:0] op_tag,
  output logic             op_pop,
  output logic             div_ready,
  output logic             div_busy,
  input  logic             div_done,
  output logic [31:0]      div_result,
  output logic [TAG_W-1:0] div_tag
);

  localparam int unsigned ITER_STEPS = XLEN / BITS_PER_STEP;

  if (LATENCY != DIV_LATENCY || ITER_STEPS != LATENCY - 2) begin : g_bad_cfg
    $error("div_exec_unit: LATENCY must be 6 and 32/BITS_PER_STEP must equal LATENCY-2");
  end

  div_state_e       state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  div_func_e        func_q, func_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [XLEN-1:0]  dvd_q, dvd_d;
  logic [XLEN-1:0]  dvs_q, dvs_d;
  logic [XLEN:0]    rem_q, rem_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             bzero_q, bzero_d;
  logic             ovf_q, ovf_d;
  logic [XLEN-1:0]  res_q, res_d;
  logic [TAG_W-1:0] otag_q, otag_d;

  div_func_e              func_in;
  logic                   sgn_in;
  logic [XLEN:0]          step_rem;
  logic [BITS_PER_STEP-1:0] step_q;
  logic [XLEN-1:0]        q_fix, r_fix, fixed;
  logic                   is_rem;

  assign div_ready  = op_valid;
  assign op_pop     = div_done;
  assign div_busy   = (state_q != IDLE);
  assign div_result = res_q;
  assign div_tag    = otag_q;

  assign func_in = div_func_e'(op_func);
  assign sgn_in  = func_is_signed(func_in);

  div_step #(.BITS(BITS_PER_STEP)) u_step (
    .rem_i     (rem_q),
    .bits_i    (dvd_q[XLEN-1 -: BITS_PER_STEP]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  // With b=0 every step subtracts zero, so the raw remainder is |a| and the
  // sign fixup restores a exactly; only the quotient needs an explicit override.
  always_comb begin
    is_rem = (func_q == REM) || (func_q == REMU);
    q_fix  = qneg_q ? -quo_q : quo_q;
    r_fix  = rneg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
    if (is_rem) begin
      fixed = ovf_q ? '0 : r_fix;
    end else if (bzero_q) begin
      fixed = '1;
    end else if (ovf_q) begin
      fixed = 32'h8000_0000;
    end else begin
      fixed = q_fix;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    func_d  = func_q;
    tag_d   = tag_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    bzero_d = bzero_q;
    ovf_d   = ovf_q;
    res_d   = res_q;
    otag_d  = otag_q;
    case (state_q)
      IDLE: begin
        if (div_done) begin
          state_d = ITER;
          cnt_d   = '0;
          func_d  = func_in;
          tag_d   = op_tag;
          dvd_d   = (sgn_in && op_a[31]) ? -op_a : op_a;
          dvs_d   = (sgn_in && op_b[31]) ? -op_b : op_b;
          rem_d   = '0;
          quo_d   = '0;
          qneg_d  = sgn_in && (op_a[31] ^ op_b[31]);
          rneg_d  = sgn_in && op_a[31];
          bzero_d = (op_b == '0);
          ovf_d   = sgn_in && (op_a == 32'h8000_0000) && (op_b == '1);
        end
      end
      ITER: begin
        rem_d = step_rem;
        quo_d = {quo_q[XLEN-BITS_PER_STEP-1:0], step_q};
        dvd_d = dvd_q << BITS_PER_STEP;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'(ITER_STEPS - 1)) state_d = FIXUP;
      end
      FIXUP: begin
        state_d = DONE;
        res_d   = fixed;
        otag_d  = tag_q;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      func_q  <= DIV;
      tag_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      bzero_q <= 1'b0;
      ovf_q   <= 1'b0;
      res_q   <= '0;
      otag_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      func_q  <= func_d;
      tag_q   <= tag_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      bzero_q <= bzero_d;
      ovf_q   <= ovf_d;
      res_q   <= res_d;
      otag_q  <= otag_d;
    end
  end

endmodule

// File: tb/tb_div_exec_unit.sv
// Scoreboard bench for div_exec_unit: expected results queued at grant, popped at T+6.
module tb_div_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [1:0]  op_func;
  logic [31:0] op_a, op_b;
  logic [5:0]  op_tag;
  logic        op_pop, div_ready, div_busy, div_done;
  logic [31:0] div_result;
  logic [5:0]  div_tag;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [37:0] sb_q[$];
  logic [31:0] last_res;
  logic [5:0]  last_tag;

  div_exec_unit #(.LATENCY(6), .BITS_PER_STEP(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .op_valid   (op_valid),
    .op_func    (op_func),
    .op_a       (op_a),
    .op_b       (op_b),
    .op_tag     (op_tag),
    .op_pop     (op_pop),
    .div_ready  (div_ready),
    .div_busy   (div_busy),
    .div_done   (div_done),
    .div_result (div_result),
    .div_tag    (div_tag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF && f == 2'b00) return 32'h8000_0000;
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF && f == 2'b10) return 32'd0;
    case (f)
      2'b00:   return 32'(sa / sb);
      2'b01:   return a / b;
      2'b10:   return 32'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  task automatic drive_grant(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                             input logic [5:0] t);
    @(negedge clk);
    check("busy_before_grant", 32'(div_busy), 32'd0);
    op_valid = 1'b1;
    op_func  = f;
    op_a     = a;
    op_b     = b;
    op_tag   = t;
    #1;
    check("ready_follows_valid", 32'(div_ready), 32'd1);
    div_done = 1'b1;
    #1;
    check("pop_follows_done", 32'(op_pop), 32'd1);
  endtask

  task automatic run_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] t, input bit hold_valid);
    logic [37:0] e;
    drive_grant(f, a, b, t);
    sb_q.push_back({t, model(f, a, b)});
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) begin
        div_done = 1'b0;
        if (!hold_valid) op_valid = 1'b0;
      end
      check("busy_during_op", 32'(div_busy), 32'd1);
      if (k < 6) begin
        check("result_hold", div_result, last_res);
        check("tag_hold", 32'(div_tag), 32'(last_tag));
      end else if (sb_q.size() == 0) begin
        check("scoreboard_empty", 32'd0, 32'd1);
      end else begin
        e = sb_q.pop_front();
        check("result", div_result, e[31:0]);
        check("tag", 32'(div_tag), 32'(e[37:32]));
        last_res = e[31:0];
        last_tag = e[37:32];
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    op_valid = 1'b0;
    op_func  = 2'b00;
    op_a     = '0;
    op_b     = '0;
    op_tag   = '0;
    div_done = 1'b0;
    last_res = '0;
    last_tag = '0;
    #2;
    check("reset_busy", 32'(div_busy), 32'd0);
    check("reset_result", div_result, 32'd0);
    check("reset_tag", 32'(div_tag), 32'd0);
    check("ready_low", 32'(div_ready), 32'd0);
    div_done = 1'b1;
    #1;
    check("pop_comb", 32'(op_pop), 32'd1);
    div_done = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    run_op(2'b01, 32'd100, 32'd7, 6'd5, 1'b0);
    @(negedge clk);
    check("idle_after_op", 32'(div_busy), 32'd0);

    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 6'd9, 1'b0);
    run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 6'd10, 1'b0);
    run_op(2'b00, 32'h1234_5678, 32'd0, 6'd11, 1'b0);
    run_op(2'b11, 32'h1234_5678, 32'd0, 6'd12, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'd0, 6'd13, 1'b0);
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 6'd14, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 6'd15, 1'b0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'd1, 6'd16, 1'b0);
    run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 6'd17, 1'b0);

    // Back-to-back with op_valid held: second grant lands exactly at T+7.
    run_op(2'b01, 32'h22, 32'd2, 6'd20, 1'b1);
    run_op(2'b00, 32'hFFFF_FF00, 32'd16, 6'd21, 1'b1);
    op_valid = 1'b0;

    for (int n = 0; n < 8; n++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = (n % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      run_op(2'($urandom_range(0, 3)), ra, rb, 6'($urandom_range(0, 63)), 1'b0);
    end

    // Reset in the middle of an operation abandons it.
    drive_grant(2'b01, 32'd1000, 32'd3, 6'd33);
    @(negedge clk);
    div_done = 1'b0;
    op_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_busy", 32'(div_busy), 32'd0);
    check("rst_mid_result", div_result, 32'd0);
    check("rst_mid_tag", 32'(div_tag), 32'd0);
    @(negedge clk);
    rst      = 1'b0;
    last_res = '0;
    last_tag = '0;
    run_op(2'b01, 32'd1000, 32'd3, 6'd34, 1'b0);
    @(negedge clk);
    check("idle_end", 32'(div_busy), 32'd0);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
